// File: rtl/dmem_line_responder.sv
// -----------------------------------------------------------------------------
// dmem_line_responder
//
// Memory-side responder for the data-cache line interface. Acts as the backing
// store behind the cache controller: it accepts one 256-bit line read or write
// at a time and answers with a one-cycle ack exactly LATENCY cycles after the
// request was accepted. The request is latched at acceptance, so the requester's
// inputs are ignored for the rest of the transaction. The block also watches
// for requesters that drop or alter a request while it is in flight.
//
// Ports
//   clk_i         clock, all state updates on the rising edge
//   rst_i         asynchronous active-low reset (the line array is not cleared)
//   mem_enable_i  request valid, held by the requester until the ack is seen
//   mem_write_i   1 = line write, 0 = line read
//   mem_addr_i    byte address; line index = mem_addr_i[IDX_W+4:5]
//   mem_data_i    write line data
//   mem_data_o    read line data, valid in the ack cycle, held until next read ack
//   mem_ack_o     one-cycle completion pulse
//   busy_o        request in flight (BUSY or ACK state)
//   proto_err_o   sticky protocol-violation flag, cleared only by reset
// -----------------------------------------------------------------------------
module dmem_line_responder #(
   parameter int LATENCY = 10,
   parameter int DEPTH   = 512,
   parameter int IDX_W   = 9
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         mem_enable_i,
   input  logic         mem_write_i,
   input  logic [31:0]  mem_addr_i,
   input  logic [255:0] mem_data_i,
   output logic [255:0] mem_data_o,
   output logic         mem_ack_o,
   output logic         busy_o,
   output logic         proto_err_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               we_q, we_d;
   logic [255:0]       wdata_q, wdata_d;
   logic [255:0]       rdata_q, rdata_d;
   logic               err_q, err_d;

   logic [255:0]       mem_q [DEPTH];

   logic [IDX_W-1:0]   req_idx;
   logic               enter_ack;
   logic               commit_we;
   logic [IDX_W-1:0]   commit_idx;
   logic [255:0]       commit_data;
   logic               unused_addr;

   // Only the line index matters; upper bits alias modulo DEPTH lines and the
   // byte offset within a line is meaningless for whole-line transfers.
   assign req_idx     = mem_addr_i[IDX_W+4:5];
   assign unused_addr = ^{mem_addr_i[31:IDX_W+5], mem_addr_i[4:0]};

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      enter_ack   = 1'b0;
      commit_we   = we_q;
      commit_idx  = idx_q;
      commit_data = wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (mem_enable_i) begin
               idx_d   = req_idx;
               we_d    = mem_write_i;
               wdata_d = mem_data_i;
               cnt_d   = CNT_LOAD;
               if (LATENCY == 1) begin
                  // The accepting edge is also the edge entering ACK, so the
                  // commit has to use the live inputs, not the latches.
                  state_d     = ST_ACK;
                  enter_ack   = 1'b1;
                  commit_we   = mem_write_i;
                  commit_idx  = req_idx;
                  commit_data = mem_data_i;
               end else begin
                  state_d = ST_BUSY;
               end
            end
         end

         ST_BUSY: begin
            // The requester must hold the same request until it sees the ack.
            if (!mem_enable_i || (req_idx != idx_q) || (mem_write_i != we_q)) begin
               err_d = 1'b1;
            end
            if (cnt_q == '0) begin
               state_d   = ST_ACK;
               enter_ack = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_ACK: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Read data is captured on the edge entering ACK; write acks leave the
      // read data register untouched.
      if (enter_ack && !commit_we) begin
         rdata_d = mem_q[commit_idx];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // NOTE: the line array has no reset; clearing 512 wide lines is neither
   // needed nor mappable to RAM. A reset mid-request still blocks the commit
   // because state_q is forced to IDLE and enter_ack cannot fire.
   always_ff @(posedge clk_i) begin
      if (enter_ack && commit_we) begin
         mem_q[commit_idx] <= commit_data;
      end
   end

   assign mem_data_o  = rdata_q;
   assign mem_ack_o   = (state_q == ST_ACK);
   assign busy_o      = (state_q != ST_IDLE);
   assign proto_err_o = err_q;

endmodule

// File: tb/tb_dmem_line_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_line_responder
//
// Directed bench for dmem_line_responder. A LATENCY=10 instance covers reads,
// writes, aliasing, protocol errors and reset abort; a LATENCY=1 instance
// covers the direct-to-ACK path and back-to-back requests.
// -----------------------------------------------------------------------------
module tb_dmem_line_responder;

   localparam logic [255:0] D_A5 = {32{8'hA5}};
   localparam logic [255:0] D_W1 = {4{64'h1234_5678_9ABC_DEFF}};
   localparam logic [255:0] D_W2 = {8{32'hCAFE_0001}};
   localparam logic [255:0] D_W3 = {8{32'hDEAD_BEEF}};
   localparam logic [255:0] D_W4 = {8{32'h0BAD_F00D}};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_i;

   // LATENCY=10 instance
   logic         en, we;
   logic [31:0]  addr;
   logic [255:0] wdata, rdata;
   logic         ack, busy, err;

   // LATENCY=1 instance
   logic         en1, we1;
   logic [31:0]  addr1;
   logic [255:0] wdata1, rdata1;
   logic         ack1, busy1, err1;

   int checks = 0;
   int errors = 0;

   dmem_line_responder #(.LATENCY(10), .DEPTH(512), .IDX_W(9)) u_dut10 (
      .clk_i(clk), .rst_i(rst_i),
      .mem_enable_i(en), .mem_write_i(we), .mem_addr_i(addr), .mem_data_i(wdata),
      .mem_data_o(rdata), .mem_ack_o(ack), .busy_o(busy), .proto_err_o(err)
   );

   dmem_line_responder #(.LATENCY(1), .DEPTH(512), .IDX_W(9)) u_dut1 (
      .clk_i(clk), .rst_i(rst_i),
      .mem_enable_i(en1), .mem_write_i(we1), .mem_addr_i(addr1), .mem_data_i(wdata1),
      .mem_data_o(rdata1), .mem_ack_o(ack1), .busy_o(busy1), .proto_err_o(err1)
   );

   // Drives one request into the LATENCY=10 instance and reports what it saw.
   // lat is the number of edges after the accepting edge at which ack was
   // observed (-1 if it never came). If change_at >= 0 the address is switched
   // to alt_addr after that many edges.
   task automatic req10(input logic we_v, input logic [31:0] addr_v,
                        input logic [255:0] data_v, input logic [31:0] alt_addr,
                        input int change_at, output int lat, output logic busy_all,
                        output logic [255:0] rd_ack, output logic idle_after);
      logic done;
      en = 1'b1; we = we_v; addr = addr_v; wdata = data_v;
      lat = -1; busy_all = 1'b1; rd_ack = '0; done = 1'b0;
      for (int c = 0; c <= 40 && !done; c++) begin
         @(posedge clk); #1;
         if (!busy) busy_all = 1'b0;
         if (ack) begin
            done   = 1'b1;
            lat    = c;
            rd_ack = rdata;
         end
         if (c == change_at) addr = alt_addr;
      end
      en = 1'b0;
      @(posedge clk); #1;
      idle_after = !ack && !busy;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      en1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (ack !== 1'b0)   begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (err !== 1'b0)   begin errors++; $display("FAIL reset_err got %b want 0", err); end
      checks++; if (rdata !== '0)   begin errors++; $display("FAIL reset_data got %h want 0", rdata); end
      checks++; if (ack1 !== 1'b0)  begin errors++; $display("FAIL reset_ack1 got %b want 0", ack1); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b want 0", busy1); end
      rst_i = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_read();
      int lat; logic ball; logic [255:0] rd; logic idle;
      // Preload line 32 (addr 0x400) through the port.
      req10(1'b1, 32'h0000_0400, D_A5, '0, -1, lat, ball, rd, idle);
      checks++; if (lat !== 10)   begin errors++; $display("FAIL preload_lat got %0d want 10", lat); end
      checks++; if (rd !== '0)    begin errors++; $display("FAIL preload_wack_data got %h want 0", rd); end
      req10(1'b0, 32'h0000_0400, '0, '0, -1, lat, ball, rd, idle);
      checks++; if (lat !== 10)   begin errors++; $display("FAIL read_lat got %0d want 10", lat); end
      checks++; if (rd !== D_A5)  begin errors++; $display("FAIL read_data got %h want %h", rd, D_A5); end
      checks++; if (ball !== 1'b1) begin errors++; $display("FAIL read_busy got %b want 1", ball); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL read_idle_after got %b want 1", idle); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL read_err got %b want 0", err); end
   endtask

   task automatic test_write_read();
      int lat; logic ball; logic [255:0] rd; logic idle;
      req10(1'b1, 32'h0000_0040, D_W1, '0, -1, lat, ball, rd, idle);
      checks++; if (lat !== 10)   begin errors++; $display("FAIL write_lat got %0d want 10", lat); end
      checks++; if (rd !== D_A5)  begin errors++; $display("FAIL write_ack_data_held got %h want %h", rd, D_A5); end
      req10(1'b0, 32'h0000_0040, '0, '0, -1, lat, ball, rd, idle);
      checks++; if (rd !== D_W1)  begin errors++; $display("FAIL wr_rd_data got %h want %h", rd, D_W1); end
   endtask

   task automatic test_alias();
      int lat; logic ball; logic [255:0] rd; logic idle;
      req10(1'b1, 32'h0000_4020, D_W2, '0, -1, lat, ball, rd, idle);
      req10(1'b0, 32'h0000_0020, '0, '0, -1, lat, ball, rd, idle);
      checks++; if (rd !== D_W2)  begin errors++; $display("FAIL alias_data got %h want %h", rd, D_W2); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL alias_err got %b want 0", err); end
   endtask

   task automatic test_addr_change();
      int lat; logic ball; logic [255:0] rd; logic idle;
      req10(1'b0, 32'h0000_0040, '0, 32'h0000_0400, 3, lat, ball, rd, idle);
      checks++; if (lat !== 10)   begin errors++; $display("FAIL chg_lat got %0d want 10", lat); end
      checks++; if (rd !== D_W1)  begin errors++; $display("FAIL chg_data got %h want %h", rd, D_W1); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL chg_err got %b want 1", err); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL chg_err_sticky got %b want 1", err); end
   endtask

   task automatic test_reset_abort();
      int lat; logic ball; logic [255:0] rd; logic idle;
      logic ack_seen;
      ack_seen = 1'b0;
      en = 1'b1; we = 1'b1; addr = 32'h0000_0040; wdata = D_W3;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (ack) ack_seen = 1'b1;
      end
      rst_i = 1'b0;
      en = 1'b0;
      #1;
      checks++; if (ack !== 1'b0)  begin errors++; $display("FAIL abort_ack got %b want 0", ack); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
      checks++; if (err !== 1'b0)  begin errors++; $display("FAIL abort_err got %b want 0", err); end
      checks++; if (rdata !== '0)  begin errors++; $display("FAIL abort_data got %h want 0", rdata); end
      repeat (2) @(posedge clk);
      #1;
      rst_i = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (ack) ack_seen = 1'b1;
      end
      checks++; if (ack_seen !== 1'b0) begin errors++; $display("FAIL abort_no_ack got %b want 0", ack_seen); end
      req10(1'b0, 32'h0000_0040, '0, '0, -1, lat, ball, rd, idle);
      checks++; if (rd !== D_W1)  begin errors++; $display("FAIL abort_line_kept got %h want %h", rd, D_W1); end
   endtask

   task automatic test_back_to_back_lat1();
      logic exp_pat [7];
      exp_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      en1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0060; wdata1 = D_W4;
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         checks++;
         if (ack1 !== exp_pat[c]) begin
            errors++; $display("FAIL l1_ack[%0d] got %b want %b", c, ack1, exp_pat[c]);
         end
         checks++;
         if (busy1 !== exp_pat[c]) begin
            errors++; $display("FAIL l1_busy[%0d] got %b want %b", c, busy1, exp_pat[c]);
         end
         if (c == 0) begin
            checks++; if (rdata1 !== '0) begin errors++; $display("FAIL l1_wack_data got %h want 0", rdata1); end
            we1 = 1'b0;
         end
         if (c == 2 || c == 4) begin
            checks++;
            if (rdata1 !== D_W4) begin errors++; $display("FAIL l1_rd_data[%0d] got %h want %h", c, rdata1, D_W4); end
         end
         if (c == 4) en1 = 1'b0;
      end
      checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL l1_err got %b want 0", err1); end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write_read();
      test_alias();
      test_addr_change();
      test_reset_abort();
      test_back_to_back_lat1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
